// File: rtl/pdp8_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_pkg -- shared types for the PDP-8 memory arbiter slice.
//
// Provides the address/data width macros (`ADDR_WIDTH, `DATA_WIDTH, both 12)
// and the arbiter FSM state and transaction owner enums.
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        MEM_WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_IFD,
        OWN_EXEC_RD,
        OWN_EXEC_WR
    } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// ---------------------------------------------------------------------------
// mem_arb_sel -- combinational requester select for mem_arbiter.
//
// Ports:
//   ifd_req, exec_rd_req, exec_wr_req  in   pending requests
//   last_exec                          in   class granted last was EXEC
//                                           (only with MEM_ARB_RR_EN)
//   grant                              out  some request is pending
//   owner                              out  selected requester
//
// Macro MEM_ARB_RR_EN: round-robin between the EXEC and IFD classes.
// Undefined: fixed priority exec write > exec read > IFD read.
// Inside the EXEC class a write always beats a read.
// ---------------------------------------------------------------------------
module mem_arb_sel
    import pdp8_pkg::*;
(
    input  logic   ifd_req,
    input  logic   exec_rd_req,
    input  logic   exec_wr_req,
`ifdef MEM_ARB_RR_EN
    input  logic   last_exec,
`endif
    output logic   grant,
    output owner_t owner
);

    logic   exec_req;
    owner_t exec_owner;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // can leave it unassigned and infer a latch.
        exec_req   = exec_wr_req | exec_rd_req;
        exec_owner = exec_wr_req ? OWN_EXEC_WR : OWN_EXEC_RD;
        grant      = exec_req | ifd_req;
        owner      = OWN_IFD;
`ifdef MEM_ARB_RR_EN
        // EXEC yields only on a tie when it also won the previous grant.
        if (exec_req && !(ifd_req && last_exec)) begin
            owner = exec_owner;
        end
`else
        if (exec_req) begin
            owner = exec_owner;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- single-port memory arbiter for the IFD and EXEC units.
//
// Ports:
//   clk, reset_n (sync, active-low)
//   ifd_rd_req/addr  -> ifd_rd_data/valid     IFD read channel
//   exec_rd_req/addr -> exec_rd_data/valid    EXEC read channel
//   exec_wr_req/addr/data -> exec_wr_ack      EXEC write channel
//   mem_rd_req/addr, mem_rd_data              memory read port (1-cycle data)
//   mem_wr_req/addr/data                      memory write port
//   busy                                      FSM not in IDLE
//
// Macro MEM_ARB_RR_EN enables round-robin between EXEC and IFD; without it
// the select is fixed priority and the last-grant register does not exist.
//
// Timing: request sampled in IDLE at T -> memory access at T+1 (GRANT).
// Writes ack at T+1 and return to IDLE at T+2. Reads wait T+2 (MEM_WAIT),
// respond at T+3 (RESP) and re-arbitrate at T+4.
// ---------------------------------------------------------------------------
module mem_arbiter
    import pdp8_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ifd_rd_req,
    input  logic [`ADDR_WIDTH-1:0] ifd_rd_addr,
    output logic [`DATA_WIDTH-1:0] ifd_rd_data,
    output logic                   ifd_rd_valid,
    input  logic                   exec_rd_req,
    input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [`DATA_WIDTH-1:0] exec_rd_data,
    output logic                   exec_rd_valid,
    input  logic                   exec_wr_req,
    input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [`DATA_WIDTH-1:0] exec_wr_data,
    output logic                   exec_wr_ack,
    output logic                   mem_rd_req,
    output logic [`ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [`DATA_WIDTH-1:0] mem_rd_data,
    output logic                   mem_wr_req,
    output logic [`ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [`DATA_WIDTH-1:0] mem_wr_data,
    output logic                   busy
);

    arb_state_t state;
    owner_t     owner;
    logic       sel_grant;
    owner_t     sel_owner;

`ifdef MEM_ARB_RR_EN
    logic       last_exec;
`endif

    mem_arb_sel u_sel (
        .ifd_req     (ifd_rd_req),
        .exec_rd_req (exec_rd_req),
        .exec_wr_req (exec_wr_req),
`ifdef MEM_ARB_RR_EN
        .last_exec   (last_exec),
`endif
        .grant       (sel_grant),
        .owner       (sel_owner)
    );

`ifdef MEM_ARB_RR_EN
    // Remembers which class won the last arbitration; reset favours EXEC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_exec <= 1'b0;
        end else if (state == IDLE && sel_grant) begin
            last_exec <= (sel_owner != OWN_IFD);
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= OWN_IFD;
            ifd_rd_data   <= '0;
            ifd_rd_valid  <= 1'b0;
            exec_rd_data  <= '0;
            exec_rd_valid <= 1'b0;
            exec_wr_ack   <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            mem_wr_req    <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
        end else begin
            // NOTE: strobes default low each cycle and are raised only in
            // the state that owns them, which makes them one-cycle pulses.
            ifd_rd_valid  <= 1'b0;
            exec_rd_valid <= 1'b0;
            exec_wr_ack   <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_wr_req    <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_grant) begin
                        owner <= sel_owner;
                        state <= GRANT;
                        // Address/data are latched straight into the memory
                        // port registers, which then hold them while idle.
                        case (sel_owner)
                            OWN_EXEC_WR: begin
                                mem_wr_req  <= 1'b1;
                                mem_wr_addr <= exec_wr_addr;
                                mem_wr_data <= exec_wr_data;
                                exec_wr_ack <= 1'b1;
                            end
                            OWN_EXEC_RD: begin
                                mem_rd_req  <= 1'b1;
                                mem_rd_addr <= exec_rd_addr;
                            end
                            default: begin
                                mem_rd_req  <= 1'b1;
                                mem_rd_addr <= ifd_rd_addr;
                            end
                        endcase
                    end
                end

                GRANT: begin
                    state <= (owner == OWN_EXEC_WR) ? IDLE : MEM_WAIT;
                end

                MEM_WAIT: begin
                    // Memory data is valid this cycle; route it to the owner.
                    if (owner == OWN_EXEC_RD) begin
                        exec_rd_data  <= mem_rd_data;
                        exec_rd_valid <= 1'b1;
                    end else begin
                        ifd_rd_data   <= mem_rd_data;
                        ifd_rd_valid  <= 1'b1;
                    end
                    state <= RESP;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 No module parameters; widths SHALL come from `ADDR_WIDTH (12) and `DATA_WIDTH (12) in pdp8_pkg.
REQ-002 clk  input  1  single clock; all logic SHALL be on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 ifd_rd_req  input  1  IFD read request, held until ifd_rd_valid.
REQ-005 ifd_rd_addr  input  `ADDR_WIDTH  IFD read address, stable while ifd_rd_req.
REQ-006 ifd_rd_data  output  `DATA_WIDTH  IFD read data, registered.
REQ-007 ifd_rd_valid  output  1  one-cycle pulse, ifd_rd_data valid.
REQ-008 exec_rd_req  input  1  EXEC read request, held until exec_rd_valid.
REQ-009 exec_rd_addr  input  `ADDR_WIDTH  EXEC read address.
REQ-010 exec_rd_data  output  `DATA_WIDTH  EXEC read data, registered.
REQ-011 exec_rd_valid  output  1  one-cycle pulse, exec_rd_data valid.
REQ-012 exec_wr_req  input  1  EXEC write request, held until exec_wr_ack.
REQ-013 exec_wr_addr / exec_wr_data  input  `ADDR_WIDTH / `DATA_WIDTH  write address/data.
REQ-014 exec_wr_ack  output  1  one-cycle pulse, write issued to memory.
REQ-015 mem_rd_req / mem_rd_addr  output  1 / `ADDR_WIDTH  memory read port; memory returns data on mem_rd_data the cycle after mem_rd_req.
REQ-016 mem_rd_data  input  `DATA_WIDTH  memory read data.
REQ-017 mem_wr_req / mem_wr_addr / mem_wr_data  output  1 / `ADDR_WIDTH / `DATA_WIDTH  memory write port.
REQ-018 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, GRANT, MEM_WAIT, RESP; enum in pdp8_pkg.
REQ-020 In IDLE with any request pending, arbiter SHALL select one, latch its address/data and owner, and go to GRANT next cycle.
REQ-021 Default priority: exec_wr_req > exec_rd_req > ifd_rd_req; simultaneous EXEC read and write SHALL serve the write first.
REQ-022 GRANT: exactly one of mem_rd_req/mem_wr_req high for exactly one cycle with latched address/data; never both.
REQ-023 Write: exec_wr_ack SHALL pulse in GRANT; next state IDLE (2 cycles request-to-IDLE).
REQ-024 Read: GRANT -> MEM_WAIT, capture mem_rd_data at end of MEM_WAIT -> RESP, owner's *_rd_valid high one cycle with data -> IDLE.
REQ-025 Read latency: request seen in IDLE at cycle T SHALL yield *_rd_valid at T+3; next arbitration at T+4.
REQ-026 Requests dropped mid-transaction SHALL NOT abort it; response still issued.
REQ-027 Request inputs sampled only in IDLE; requester deasserts the cycle after valid/ack, so no duplicate service occurs.
REQ-028 *_rd_data SHALL hold last value between responses; unselected port's data unchanged.
REQ-029 mem_* address/data outputs SHALL hold last latched value when idle.

Reset
REQ-030 reset_n low at posedge SHALL force IDLE; all req/valid/ack/busy outputs 0; all data/address outputs 0; arbitration history cleared.
REQ-031 Reset mid-transaction SHALL abort it with no valid/ack issued.

Configuration
REQ-032 Macro MEM_ARB_RR_EN defined: round-robin between EXEC (write-before-read within EXEC) and IFD classes via one-bit last-grant register; class granted last loses a tie next time; reset favours EXEC.
REQ-033 MEM_ARB_RR_EN undefined: fixed priority per REQ-021; last-grant register absent.

Structure
REQ-034 pdp8_pkg SHALL hold the FSM state enum and an owner enum (OWN_IFD, OWN_EXEC_RD, OWN_EXEC_WR); width macros reused.
REQ-035 One sub-module mem_arb_sel (combinational priority/round-robin select) SHALL be used; FSM and datapath stay in mem_arbiter.

Verification
REQ-036 ifd_rd_req, addr 12'h200, memory returns 12'h5A5 -> mem_rd_req at T+1, ifd_rd_valid with 12'h5A5 at T+3.
REQ-037 exec_wr_req addr 12'h010 data 12'h777 -> mem_wr_req/exec_wr_ack at T+1 with those values, busy low at T+2.
REQ-038 exec_rd_req, exec_wr_req, ifd_rd_req all at T -> service order write, EXEC read, IFD read (fixed); with MEM_ARB_RR_EN, IFD served before second EXEC access.
REQ-039 ifd_rd_req dropped in MEM_WAIT -> ifd_rd_valid still pulses at T+3.
REQ-040 reset_n low in MEM_WAIT -> no valid, all outputs 0 next cycle, new request after reset served with normal latency.
